dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 52 +++++
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: CPU MEM-stage port, DMA port, memory port and
// statistics. The arbiter uses the slave modport; requesters, the memory
// model and the bench use the master modport.
interface dmem_arbiter_if #(
  parameter int AW = 32
);
  // CPU MEM-stage port
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          cpu_stall;
  // DMA port
  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [31:0]   dma_wdata;
  logic          dma_gnt;
  logic [31:0]   dma_rdata;
  logic          dma_rvalid;
  // Single-ported memory
  logic          mem_re;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  // Statistics
  logic [15:0]   stat_cpu;
  logic [15:0]   stat_dma;
  logic [15:0]   stat_conf;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_re, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output stat_cpu, stat_dma, stat_conf
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_re, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  stat_cpu, stat_dma, stat_conf
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported data memory between the CPU MEM
// stage and a DMA engine. CPU has priority unless the DMA has been denied
// STARVE_LIMIT consecutive cycles. Reads take the issue cycle plus one
// return cycle (CPU_RD / DMA_RD) during which no access is issued.
// Optional feature: define DMEM_ARB_STATS_EN to build saturating grant and
// conflict counters; otherwise stat_* are constant zero with no flops.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int AW           = 32
) (
  input  logic              clk,
  input  logic              reset,
  dmem_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    DMA_RD = 2'd2
  } state_t;

  localparam logic [7:0] LIM = 8'(STARVE_LIMIT);

  state_t        r_state;
  logic [7:0]    r_wait_cnt;

  logic          w_idle;
  logic          w_cpu_win;
  logic          w_dma_win;
  logic [AW-1:0] w_mem_addr;

  // Arbitration: only decided in IDLE; reset low suppresses any issue so
  // the memory strobes are forced inactive asynchronously.
  always_comb begin
    w_idle    = (r_state == IDLE);
    w_dma_win = reset & w_idle & bus.dma_req &
                (~bus.cpu_req | (r_wait_cnt == LIM));
    w_cpu_win = reset & w_idle & bus.cpu_req & ~w_dma_win;
  end

  // Memory and requester outputs decoded from the grant and the FSM state.
  // Request fields are never latched: the winner's fields pass straight through.
  always_comb begin
    bus.mem_re     = (w_cpu_win & ~bus.cpu_we) | (w_dma_win & ~bus.dma_we);
    bus.mem_we     = (w_cpu_win &  bus.cpu_we) | (w_dma_win &  bus.dma_we);
    w_mem_addr     = w_dma_win ? bus.dma_addr  : bus.cpu_addr;
    bus.mem_wdata  = w_dma_win ? bus.dma_wdata : bus.cpu_wdata;
    bus.dma_gnt    = w_dma_win;
    bus.dma_rvalid = (r_state == DMA_RD);
    bus.dma_rdata  = (r_state == DMA_RD) ? bus.mem_rdata : 32'd0;
    bus.cpu_rdata  = ((r_state == CPU_RD) && bus.cpu_req) ? bus.mem_rdata : 32'd0;
    // Stall while waiting for the bus, during own read issue, or behind a DMA read;
    // a granted CPU write completes without stalling.
    bus.cpu_stall  = reset & bus.cpu_req &
                     ((w_idle & ~(w_cpu_win & bus.cpu_we)) | (r_state == DMA_RD));
  end

  assign bus.mem_addr = w_mem_addr;

  // FSM: reads park for one return cycle, writes stay in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cpu_win && !bus.cpu_we)      r_state <= CPU_RD;
          else if (w_dma_win && !bus.dma_we) r_state <= DMA_RD;
          else                               r_state <= IDLE;
        end
        CPU_RD:  r_state <= IDLE;
        DMA_RD:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Starvation counter: counts consecutive denied DMA cycles, saturating at
  // the limit; any grant or a dropped request restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= 8'd0;
    end else if (!bus.dma_req || w_dma_win) begin
      r_wait_cnt <= 8'd0;
    end else if (r_wait_cnt < LIM) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic        w_conflict;
  logic [15:0] r_stat_cpu;
  logic [15:0] r_stat_dma;
  logic [15:0] r_stat_conf;

  assign w_conflict = w_idle & bus.cpu_req & bus.dma_req;

  // Saturating grant and conflict counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_cpu  <= 16'd0;
      r_stat_dma  <= 16'd0;
      r_stat_conf <= 16'd0;
    end else begin
      if (w_cpu_win && r_stat_cpu != 16'hFFFF)   r_stat_cpu  <= r_stat_cpu + 16'd1;
      if (w_dma_win && r_stat_dma != 16'hFFFF)   r_stat_dma  <= r_stat_dma + 16'd1;
      if (w_conflict && r_stat_conf != 16'hFFFF) r_stat_conf <= r_stat_conf + 16'd1;
    end
  end

  assign bus.stat_cpu  = r_stat_cpu;
  assign bus.stat_dma  = r_stat_dma;
  assign bus.stat_conf = r_stat_conf;
`else
  assign bus.stat_cpu  = 16'd0;
  assign bus.stat_dma  = 16'd0;
  assign bus.stat_conf = 16'd0;
`endif

endmodule
